// File: rtl/mem_wb_cycle.sv
// rtl/mem_wb_cycle.sv - RV32I memory/writeback stage with req/ack data bus; MEM_ERR_CAPTURE_EN enables fault address capture
module mem_wb_cycle #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        LoadM,
    input  logic        StoreM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        mem_err,
    output logic [1:0]  mem_err_cause,
    output logic [31:0] mem_err_addr
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic              regwrite_w_q, regwrite_w_d;
    logic [4:0]        rdw_q, rdw_d;
    logic [31:0]       resultw_q, resultw_d;
    logic              mem_err_q, mem_err_d;
    logic [1:0]        mem_err_cause_q, mem_err_cause_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
    logic [4:0]        lat_rd_q, lat_rd_d;
    logic [2:0]        lat_f3_q, lat_f3_d;
    logic [1:0]        lat_off_q, lat_off_d;
    logic              lat_rw_q, lat_rw_d, lat_load_q, lat_load_d;

    logic              illegal, misalign, fault_now;
    logic [1:0]        fault_cause;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_data, st_wdata;
    logic [3:0]        st_be;

    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        lane_byte = dmem_rdata[7:0];
        case (lat_off_q)
            2'd1:    lane_byte = dmem_rdata[15:8];
            2'd2:    lane_byte = dmem_rdata[23:16];
            2'd3:    lane_byte = dmem_rdata[31:24];
            default: lane_byte = dmem_rdata[7:0];
        endcase
        lane_half = lat_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'h0, lane_byte};
            3'b101:  load_data = {16'h0, lane_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ALUResultM[1:0];
                st_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ALUResultM[1:0];
                st_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = WriteDataM;
            end
        endcase
    end

    // A load with StoreM also set is treated as a load.
    assign illegal  = LoadM ? (funct3M[1:0] == 2'b11 || funct3M == 3'b110)
                            : (funct3M[2] || funct3M[1:0] == 2'b11);
    assign misalign = (funct3M[1:0] == 2'b01 && ALUResultM[0]) ||
                      (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        dmem_be_d       = dmem_be_q;
        regwrite_w_d    = regwrite_w_q;
        rdw_d           = rdw_q;
        resultw_d       = resultw_q;
        mem_err_d       = mem_err_q;
        mem_err_cause_d = mem_err_cause_q;
        tmo_d           = tmo_q;
        lat_rd_d        = lat_rd_q;
        lat_f3_d        = lat_f3_q;
        lat_off_d       = lat_off_q;
        lat_rw_d        = lat_rw_q;
        lat_load_d      = lat_load_q;
        fault_now       = 1'b0;
        fault_cause     = 2'b00;

        case (state_q)
            IDLE: begin
                if (!ValidM) begin
                    regwrite_w_d = 1'b0;
                end else if (LoadM || StoreM) begin
                    regwrite_w_d = 1'b0;
                    if (illegal || misalign) begin
                        fault_now   = 1'b1;
                        fault_cause = illegal ? 2'b10 : 2'b01;
                    end else begin
                        lat_rd_d     = RD_M;
                        lat_f3_d     = funct3M;
                        lat_off_d    = ALUResultM[1:0];
                        lat_rw_d     = RegWriteM;
                        lat_load_d   = LoadM;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ~LoadM;
                        dmem_addr_d  = {ALUResultM[31:2], 2'b00};
                        dmem_be_d    = LoadM ? 4'b1111 : st_be;
                        dmem_wdata_d = LoadM ? 32'h0 : st_wdata;
                        tmo_d        = '0;
                        state_d      = REQ;
                    end
                end else begin
                    regwrite_w_d = RegWriteM && (RD_M != 5'd0);
                    rdw_d        = RD_M;
                    resultw_d    = (ResultSrcM == 2'b10) ? PCPlus4M : ALUResultM;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    dmem_req_d   = 1'b0;
                    state_d      = IDLE;
                    tmo_d        = '0;
                    rdw_d        = lat_rd_q;
                    regwrite_w_d = lat_load_q && lat_rw_q && (lat_rd_q != 5'd0);
                    if (lat_load_q) resultw_d = load_data;
                end else if (TIMEOUT_CYCLES != 0 && tmo_inc == TMO_LIMIT) begin
                    dmem_req_d   = 1'b0;
                    regwrite_w_d = 1'b0;
                    state_d      = IDLE;
                    tmo_d        = '0;
                    fault_now    = 1'b1;
                    fault_cause  = 2'b11;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fault_now) begin
            mem_err_d = 1'b1;
            if (!mem_err_q) mem_err_cause_d = fault_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            dmem_be_q       <= '0;
            regwrite_w_q    <= 1'b0;
            rdw_q           <= '0;
            resultw_q       <= '0;
            mem_err_q       <= 1'b0;
            mem_err_cause_q <= '0;
            tmo_q           <= '0;
            lat_rd_q        <= '0;
            lat_f3_q        <= '0;
            lat_off_q       <= '0;
            lat_rw_q        <= 1'b0;
            lat_load_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            dmem_be_q       <= dmem_be_d;
            regwrite_w_q    <= regwrite_w_d;
            rdw_q           <= rdw_d;
            resultw_q       <= resultw_d;
            mem_err_q       <= mem_err_d;
            mem_err_cause_q <= mem_err_cause_d;
            tmo_q           <= tmo_d;
            lat_rd_q        <= lat_rd_d;
            lat_f3_q        <= lat_f3_d;
            lat_off_q       <= lat_off_d;
            lat_rw_q        <= lat_rw_d;
            lat_load_q      <= lat_load_d;
        end
    end

`ifdef MEM_ERR_CAPTURE_EN
    // Timeouts report the full address latched at request time.
    logic [31:0] lat_addr_q, lat_addr_d, err_addr_q, err_addr_d;

    always_comb begin
        lat_addr_d = lat_addr_q;
        err_addr_d = err_addr_q;
        if (state_q == IDLE && state_d == REQ) lat_addr_d = ALUResultM;
        if (fault_now && !mem_err_q)
            err_addr_d = (state_q == REQ) ? lat_addr_q : ALUResultM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr_q <= '0;
            err_addr_q <= '0;
        end else begin
            lat_addr_q <= lat_addr_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign mem_err_addr = err_addr_q;
`else
    assign mem_err_addr = 32'h0;
`endif

    assign StallM        = (state_q == REQ);
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign dmem_be       = dmem_be_q;
    assign RegWriteW     = regwrite_w_q;
    assign RDW           = rdw_q;
    assign ResultW       = resultw_q;
    assign mem_err       = mem_err_q;
    assign mem_err_cause = mem_err_cause_q;
endmodule

// File: tb/tb_mem_wb_cycle.sv
// tb/tb_mem_wb_cycle.sv - directed vector bench for mem_wb_cycle (TIMEOUT_CYCLES=4)
module tb_mem_wb_cycle;
    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, LoadM, StoreM, dmem_ack;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
    logic [4:0]  RD_M;
    logic        StallM, dmem_req, dmem_we, RegWriteW, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, ResultW, mem_err_addr;
    logic [3:0]  dmem_be;
    logic [4:0]  RDW;
    logic [1:0]  mem_err_cause;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_cycle #(.TIMEOUT_CYCLES(4), .TMO_W(7)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .LoadM(LoadM), .StoreM(StoreM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .mem_err(mem_err),
        .mem_err_cause(mem_err_cause), .mem_err_addr(mem_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        exp_rw;
        logic        chk_data;
        logic [4:0]  exp_rd;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ValidM = 0; RegWriteM = 0; ResultSrcM = 0; LoadM = 0; StoreM = 0; funct3M = 0;
        ALUResultM = 0; WriteDataM = 0; RD_M = 0; PCPlus4M = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd);
        ValidM = 1; RegWriteM = ld; ResultSrcM = ld ? 2'b01 : 2'b00; LoadM = ld; StoreM = ~ld;
        funct3M = f3; ALUResultM = addr; WriteDataM = wd; RD_M = rd;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        step();
        step();
        rst = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'h0, StallM}, 32'h0);
        check({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
        check({tag, "_addr"}, dmem_addr, 32'h0);
        check({tag, "_be"}, {28'h0, dmem_be}, 32'h0);
        check({tag, "_rw"}, {31'h0, RegWriteW}, 32'h0);
        check({tag, "_rdw"}, {27'h0, RDW}, 32'h0);
        check({tag, "_res"}, ResultW, 32'h0);
        check({tag, "_err"}, {29'h0, mem_err, mem_err_cause}, 32'h0);
        check({tag, "_erraddr"}, mem_err_addr, 32'h0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] exp_err_addr;

        vecs[0] = '{1'b1, 1'b1, 2'b00, 5'd5,  32'h0000_1234, 32'h0,         1'b1, 1'b1, 5'd5,  32'h0000_1234};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 5'd1,  32'hDEAD_0000, 32'h0000_8004, 1'b1, 1'b1, 5'd1,  32'h0000_8004};
        vecs[2] = '{1'b1, 1'b1, 2'b00, 5'd0,  32'h0000_0055, 32'h0,         1'b0, 1'b1, 5'd0,  32'h0000_0055};
        vecs[3] = '{1'b1, 1'b0, 2'b00, 5'd9,  32'h0000_0077, 32'h0,         1'b0, 1'b1, 5'd9,  32'h0000_0077};
        vecs[4] = '{1'b0, 1'b1, 2'b00, 5'd4,  32'h0000_0099, 32'h0,         1'b0, 1'b0, 5'd0,  32'h0};
        vecs[5] = '{1'b1, 1'b1, 2'b00, 5'd31, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};

        do_reset();
        check_all_zero("reset");

        foreach (vecs[i]) begin
            ValidM = vecs[i].valid; RegWriteM = vecs[i].rw; ResultSrcM = vecs[i].rsrc;
            RD_M = vecs[i].rd; ALUResultM = vecs[i].alu; PCPlus4M = vecs[i].pc4;
            LoadM = 0; StoreM = 0;
            step();
            check($sformatf("vec%0d_rw", i), {31'h0, RegWriteW}, {31'h0, vecs[i].exp_rw});
            check($sformatf("vec%0d_stall", i), {31'h0, StallM}, 32'h0);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_rdw", i), {27'h0, RDW}, {27'h0, vecs[i].exp_rd});
                check($sformatf("vec%0d_res", i), ResultW, vecs[i].exp_res);
            end
        end

        // LB at 0x103, ack arrives in the third REQ cycle
        mem_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        step();
        check("lb_req", {31'h0, dmem_req}, 32'h1);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_we", {31'h0, dmem_we}, 32'h0);
        check("lb_rw_pending", {31'h0, RegWriteW}, 32'h0);
        cyc = 1;
        step();
        cyc += StallM ? 1 : 0;
        dmem_ack = 1; dmem_rdata = 32'h80FF_FF7F; ValidM = 0;
        cyc += StallM ? 1 : 0;
        check("lb_stall_cycles", cyc, 3);
        step();
        dmem_ack = 0;
        check("lb_stall_release", {31'h0, StallM}, 32'h0);
        check("lb_req_drop", {31'h0, dmem_req}, 32'h0);
        check("lb_rw", {31'h0, RegWriteW}, 32'h1);
        check("lb_rdw", {27'h0, RDW}, 32'd7);
        check("lb_res", ResultW, 32'hFFFF_FF80);

        // SH at 0x202, immediate ack
        mem_op(1'b0, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0);
        step();
        check("sh_req", {31'h0, dmem_req}, 32'h1);
        check("sh_we", {31'h0, dmem_we}, 32'h1);
        check("sh_be", {28'h0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_addr", dmem_addr, 32'h0000_0200);
        dmem_ack = 1; ValidM = 0;
        step();
        dmem_ack = 0;
        check("sh_req_drop", {31'h0, dmem_req}, 32'h0);
        check("sh_rw", {31'h0, RegWriteW}, 32'h0);
        check("sh_stall", {31'h0, StallM}, 32'h0);

        // LHU at 0x302 picks upper half, zero-extended
        mem_op(1'b1, 3'b101, 32'h0000_0302, 32'h0, 5'd12);
        step();
        dmem_ack = 1; dmem_rdata = 32'h9876_5432; ValidM = 0;
        step();
        dmem_ack = 0;
        check("lhu_res", ResultW, 32'h0000_9876);
        check("lhu_rw", {31'h0, RegWriteW}, 32'h1);

        // load to x0 never writes back
        mem_op(1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd0);
        step();
        dmem_ack = 1; dmem_rdata = 32'h1234_5678; ValidM = 0;
        step();
        dmem_ack = 0;
        check("x0_rw", {31'h0, RegWriteW}, 32'h0);

        // misaligned LW
`ifdef MEM_ERR_CAPTURE_EN
        exp_err_addr = 32'h0000_0101;
`else
        exp_err_addr = 32'h0;
`endif
        mem_op(1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd3);
        step();
        ValidM = 0;
        check("mis_req", {31'h0, dmem_req}, 32'h0);
        check("mis_stall", {31'h0, StallM}, 32'h0);
        check("mis_rw", {31'h0, RegWriteW}, 32'h0);
        check("mis_err", {31'h0, mem_err}, 32'h1);
        check("mis_cause", {30'h0, mem_err_cause}, 32'h1);
        check("mis_addr", mem_err_addr, exp_err_addr);

        // illegal store funct3 keeps first cause and address
        mem_op(1'b0, 3'b100, 32'h0000_0500, 32'h0, 5'd0);
        step();
        ValidM = 0;
        check("ill_req", {31'h0, dmem_req}, 32'h0);
        check("ill_cause_kept", {30'h0, mem_err_cause}, 32'h1);
        check("ill_addr_kept", mem_err_addr, exp_err_addr);

        // ack while idle is ignored
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        check("idle_ack_stall", {31'h0, StallM}, 32'h0);
        check("idle_ack_rw", {31'h0, RegWriteW}, 32'h0);

        // timeout with no ack
        do_reset();
`ifdef MEM_ERR_CAPTURE_EN
        exp_err_addr = 32'h0000_0404;
`else
        exp_err_addr = 32'h0;
`endif
        mem_op(1'b1, 3'b010, 32'h0000_0404, 32'h0, 5'd3);
        step();
        ValidM = 0;
        cyc = 0;
        while (StallM && cyc < 20) begin
            cyc++;
            step();
        end
        check("tmo_stall_cycles", cyc, 4);
        check("tmo_req", {31'h0, dmem_req}, 32'h0);
        check("tmo_rw", {31'h0, RegWriteW}, 32'h0);
        check("tmo_err", {31'h0, mem_err}, 32'h1);
        check("tmo_cause", {30'h0, mem_err_cause}, 32'h3);
        check("tmo_addr", mem_err_addr, exp_err_addr);

        // reset in the middle of a request
        do_reset();
        mem_op(1'b1, 3'b010, 32'h0000_0600, 32'h0, 5'd8);
        step();
        ValidM = 0;
        check("rstreq_req", {31'h0, dmem_req}, 32'h1);
        step();
        rst = 1; dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        step();
        rst = 0; dmem_ack = 0;
        check_all_zero("rst_mid_req");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
